conv1_window_gen: RTL and testbench

Producer for the first convolution stage. It accepts a raster-scan 8-bit MNIST pixel stream through a valid/ready handshake and buffers four image rows in line buffers. For every valid 5x5 position it presents a registered 25-pixel window on `data_out_0..data_out_24` with a one-cycle `o_valid` strobe, which drives the window inputs and `i_valid` of the conv1 layer. It holds off the pixel stream until that layer reports `weight_done`.

---
 rtl/conv1_window_gen.sv | 124 ++++++++++++
 tb/tb_conv1_window_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_window_gen.sv
// 5x5 sliding-window generator feeding conv1: buffers four image rows and emits one registered
// window per accepted pixel whose window lies fully inside the frame.
module conv1_window_gen #(
  parameter int unsigned WIDTH  = 28,
  parameter int unsigned HEIGHT = 28
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       weight_done,
  input  logic       s_axis_valid,
  input  logic [7:0] s_axis_data,
  output logic       s_axis_ready,
  output logic [7:0] data_out_0,  output logic [7:0] data_out_1,  output logic [7:0] data_out_2,
  output logic [7:0] data_out_3,  output logic [7:0] data_out_4,  output logic [7:0] data_out_5,
  output logic [7:0] data_out_6,  output logic [7:0] data_out_7,  output logic [7:0] data_out_8,
  output logic [7:0] data_out_9,  output logic [7:0] data_out_10, output logic [7:0] data_out_11,
  output logic [7:0] data_out_12, output logic [7:0] data_out_13, output logic [7:0] data_out_14,
  output logic [7:0] data_out_15, output logic [7:0] data_out_16, output logic [7:0] data_out_17,
  output logic [7:0] data_out_18, output logic [7:0] data_out_19, output logic [7:0] data_out_20,
  output logic [7:0] data_out_21, output logic [7:0] data_out_22, output logic [7:0] data_out_23,
  output logic [7:0] data_out_24,
  output logic       o_valid,
  output logic       frame_done
);

  localparam int unsigned K    = 5;
  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);

  typedef enum logic [0:0] {StWaitW, StStream} state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            o_valid_q, frame_done_q;
  logic            accept, last_pix;
  logic [7:0]      lb_q    [4][WIDTH];
  logic [7:0]      win_q   [K][K];
  logic [7:0]      col_pix [K];

  assign s_axis_ready = (state_q == StStream);
  assign accept       = s_axis_valid && (state_q == StStream);
  assign last_pix     = (col_q == ColW'(WIDTH - 1)) && (row_q == RowW'(HEIGHT - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // New rightmost window column, oldest row on top.
  always_comb begin
    col_pix[0] = lb_q[3][col_q];
    col_pix[1] = lb_q[2][col_q];
    col_pix[2] = lb_q[1][col_q];
    col_pix[3] = lb_q[0][col_q];
    col_pix[4] = s_axis_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StWaitW;
      col_q        <= '0;
      row_q        <= '0;
      o_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      // Leave streaming only on a frame boundary, including the edge that wraps the last pixel.
      unique case (state_q)
        StWaitW:  if (weight_done) state_q <= StStream;
        StStream: if (!weight_done && col_d == '0 && row_d == '0) state_q <= StWaitW;
        default:  state_q <= StWaitW;
      endcase
      col_q        <= col_d;
      row_q        <= row_d;
      o_valid_q    <= accept && (row_q >= RowW'(K - 1)) && (col_q >= ColW'(K - 1));
      frame_done_q <= accept && last_pix;
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][K-1] <= col_pix[r];
        end
      end
    end
  end

  // Line-buffer RAM is intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb_q[3][col_q] <= lb_q[2][col_q];
      lb_q[2][col_q] <= lb_q[1][col_q];
      lb_q[1][col_q] <= lb_q[0][col_q];
      lb_q[0][col_q] <= s_axis_data;
    end
  end

  assign o_valid    = o_valid_q;
  assign frame_done = frame_done_q;

  assign data_out_0  = win_q[0][0]; assign data_out_1  = win_q[0][1]; assign data_out_2  = win_q[0][2];
  assign data_out_3  = win_q[0][3]; assign data_out_4  = win_q[0][4]; assign data_out_5  = win_q[1][0];
  assign data_out_6  = win_q[1][1]; assign data_out_7  = win_q[1][2]; assign data_out_8  = win_q[1][3];
  assign data_out_9  = win_q[1][4]; assign data_out_10 = win_q[2][0]; assign data_out_11 = win_q[2][1];
  assign data_out_12 = win_q[2][2]; assign data_out_13 = win_q[2][3]; assign data_out_14 = win_q[2][4];
  assign data_out_15 = win_q[3][0]; assign data_out_16 = win_q[3][1]; assign data_out_17 = win_q[3][2];
  assign data_out_18 = win_q[3][3]; assign data_out_19 = win_q[3][4]; assign data_out_20 = win_q[4][0];
  assign data_out_21 = win_q[4][1]; assign data_out_22 = win_q[4][2]; assign data_out_23 = win_q[4][3];
  assign data_out_24 = win_q[4][4];

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: streams whole frames and compares every emitted
// window with windows cut directly out of a reference image array.
module tb_conv1_window_gen;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 4) * (H - 4);

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       weight_done;
  logic       s_axis_valid;
  logic [7:0] s_axis_data;
  logic       s_axis_ready;
  logic [7:0] dout [25];
  logic       o_valid;
  logic       frame_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]   img [H][W];
  logic [199:0] obs_q [$];
  bit           obs_fd [$];
  int           obs_pix [$];
  int           acc_cnt = 0;
  bit           mon_on = 1'b0;
  bit           prev_acc = 1'b0;
  bit           prev_rst = 1'b1;
  logic [199:0] prev_win = '0;

  always #5 i_clk = ~i_clk;

  conv1_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .weight_done(weight_done),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
    .data_out_0(dout[0]),   .data_out_1(dout[1]),   .data_out_2(dout[2]),   .data_out_3(dout[3]),
    .data_out_4(dout[4]),   .data_out_5(dout[5]),   .data_out_6(dout[6]),   .data_out_7(dout[7]),
    .data_out_8(dout[8]),   .data_out_9(dout[9]),   .data_out_10(dout[10]), .data_out_11(dout[11]),
    .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]), .data_out_15(dout[15]),
    .data_out_16(dout[16]), .data_out_17(dout[17]), .data_out_18(dout[18]), .data_out_19(dout[19]),
    .data_out_20(dout[20]), .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
    .data_out_24(dout[24]),
    .o_valid(o_valid), .frame_done(frame_done)
  );

  function automatic logic [199:0] pack_out();
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = dout[i];
    return w;
  endfunction

  // Window whose bottom-right pixel is (r, c), index 5*row + col, straight from the image.
  function automatic logic [199:0] exp_win(int r, int c);
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = img[r - 4 + i / 5][c - 4 + i % 5];
    return w;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'((r * W + c) % 256);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(255));
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_fd.delete();
    obs_pix.delete();
    acc_cnt = 0;
  endtask

  // Streams img in raster order; drops weight_done after drop_at accepts; bounded by a cycle budget.
  task automatic stream_frame(input int pct, input int drop_at, input int npix, output bit ok);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    ok = 1'b1;
    while (idx < npix) begin
      if (cyc > 20000) begin
        ok = 1'b0;
        break;
      end
      s_axis_valid = ($urandom_range(99) < pct);
      s_axis_data  = img[idx / W][idx % W];
      acc = s_axis_valid && s_axis_ready;
      @(posedge i_clk);
      #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx == drop_at) weight_done = 1'b0;
      end
    end
    s_axis_valid = 1'b0;
  endtask

  // Per-cycle protocol checks, sampled on the falling edge.
  always @(negedge i_clk) begin
    logic [199:0] cur;
    cur = pack_out();
    if (mon_on) begin
      if (o_valid === 1'b1) begin
        obs_q.push_back(cur);
        obs_fd.push_back(frame_done);
        obs_pix.push_back(acc_cnt - 1);
      end
      n_total++;
      if (o_valid === 1'b1 && !prev_acc)
        $display("FAIL mon_valid_without_accept t=%0t o_valid=%b required 0", $time, o_valid);
      else n_pass++;
      n_total++;
      if (!prev_acc && !prev_rst && cur !== prev_win)
        $display("FAIL mon_data_hold t=%0t got %h required %h", $time, cur, prev_win);
      else n_pass++;
      n_total++;
      if (frame_done === 1'b1 && o_valid !== 1'b1)
        $display("FAIL mon_frame_done_alone t=%0t o_valid=%b required 1", $time, o_valid);
      else n_pass++;
    end
    prev_win = cur;
    prev_acc = s_axis_valid && s_axis_ready && !i_rst;
    prev_rst = i_rst;
    if (prev_acc) acc_cnt++;
  end

  task automatic test_reset();
    i_rst = 1'b1; weight_done = 1'b0; s_axis_valid = 1'b0; s_axis_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_total++;
    if (s_axis_ready !== 1'b0) $display("FAIL reset_ready got %b required 0", s_axis_ready);
    else n_pass++;
    n_total++;
    if (o_valid !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL reset_strobes got %b%b required 00", o_valid, frame_done);
    else n_pass++;
    n_total++;
    if (pack_out() !== '0) $display("FAIL reset_window got %h required 0", pack_out());
    else n_pass++;
    i_rst = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_weight_handshake();
    s_axis_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      n_total++;
      if (s_axis_ready !== 1'b0 || o_valid !== 1'b0)
        $display("FAIL hold_off cyc=%0d ready=%b o_valid=%b required 0 0", i, s_axis_ready, o_valid);
      else n_pass++;
    end
    s_axis_valid = 1'b0;
    weight_done  = 1'b1;
    #1;
    n_total++;
    if (s_axis_ready !== 1'b0) $display("FAIL ready_comb_path got %b required 0", s_axis_ready);
    else n_pass++;
    @(posedge i_clk);
    #1;
    n_total++;
    if (s_axis_ready !== 1'b1) $display("FAIL ready_rise got %b required 1", s_axis_ready);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ok;
    int rc [H];
    fill_ramp();
    clear_obs();
    stream_frame(100, -1, NPIX, ok);
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (!ok) $display("FAIL full_timeout ok=%b required 1", ok); else n_pass++;
    n_total++;
    if (obs_q.size() != NWIN) $display("FAIL full_count got %0d required %0d", obs_q.size(), NWIN);
    else n_pass++;
    if (obs_q.size() == NWIN) begin
      n_total++;
      if (obs_pix[0] != 116) $display("FAIL full_first_latency pix=%0d required 116", obs_pix[0]);
      else n_pass++;
      n_total++;
      if (obs_q[0][7:0] !== 8'd0 || obs_q[0][39:32] !== 8'd4 || obs_q[0][167:160] !== 8'd112 ||
          obs_q[0][199:192] !== 8'd116)
        $display("FAIL full_first_corners got %0d %0d %0d %0d required 0 4 112 116",
                 obs_q[0][7:0], obs_q[0][39:32], obs_q[0][167:160], obs_q[0][199:192]);
      else n_pass++;
      n_total++;
      if (obs_q[NWIN-1][199:192] !== 8'd15 || obs_fd[NWIN-1] !== 1'b1)
        $display("FAIL full_last got d24=%0d fd=%b required 15 1", obs_q[NWIN-1][199:192],
                 obs_fd[NWIN-1]);
      else n_pass++;
      n_total++;
      if (obs_pix[23] != 4 * W + 27 || obs_pix[24] != 5 * W + 4 || obs_q[24][199:192] !== 8'd144)
        $display("FAIL row_boundary got pix %0d,%0d d24=%0d required 139,144 144", obs_pix[23],
                 obs_pix[24], obs_q[24][199:192]);
      else n_pass++;
      for (int k = 0; k < NWIN; k++) begin
        n_total++;
        if (obs_q[k] !== exp_win(4 + k / 24, 4 + k % 24) || obs_fd[k] !== (k == NWIN - 1))
          $display("FAIL full_win k=%0d got %h fd=%b required %h fd=%b", k, obs_q[k], obs_fd[k],
                   exp_win(4 + k / 24, 4 + k % 24), k == NWIN - 1);
        else n_pass++;
      end
      for (int r = 0; r < H; r++) rc[r] = 0;
      for (int k = 0; k < NWIN; k++) rc[obs_pix[k] / W]++;
      for (int r = 4; r < H; r++) begin
        n_total++;
        if (rc[r] != 24) $display("FAIL row_count row=%0d got %0d required 24", r, rc[r]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_valid();
    bit ok;
    fill_ramp();
    clear_obs();
    stream_frame(50, -1, NPIX, ok);
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (!ok || obs_q.size() != NWIN)
      $display("FAIL rand_count ok=%b got %0d required 1 %0d", ok, obs_q.size(), NWIN);
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < NWIN; k++) begin
      n_total++;
      if (obs_q[k] !== exp_win(4 + k / 24, 4 + k % 24) || obs_pix[k] != (4 + k / 24) * W + 4 + k % 24)
        $display("FAIL rand_win k=%0d got %h at %0d required %h", k, obs_q[k], obs_pix[k],
                 exp_win(4 + k / 24, 4 + k % 24));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_ramp();
    clear_obs();
    stream_frame(100, 400, NPIX, ok);
    n_total++;
    if (!ok || s_axis_ready !== 1'b0)
      $display("FAIL b2b_ready_fall ok=%b ready=%b required 1 0", ok, s_axis_ready);
    else n_pass++;
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (obs_q.size() != NWIN || obs_q[obs_q.size()-1] !== exp_win(H - 1, W - 1))
      $display("FAIL b2b_frame1 got %0d windows required %0d", obs_q.size(), NWIN);
    else n_pass++;
    s_axis_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      n_total++;
      if (s_axis_ready !== 1'b0) $display("FAIL b2b_hold cyc=%0d ready=%b required 0", i, s_axis_ready);
      else n_pass++;
    end
    s_axis_valid = 1'b0;
    fill_random();
    clear_obs();
    weight_done = 1'b1;
    stream_frame(100, -1, NPIX, ok);
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (!ok || obs_q.size() != NWIN || obs_pix[0] != 116)
      $display("FAIL b2b_frame2 ok=%b got %0d windows required %0d", ok, obs_q.size(), NWIN);
    else n_pass++;
    for (int k = 0; k < obs_q.size() && k < NWIN; k++) begin
      n_total++;
      if (obs_q[k] !== exp_win(4 + k / 24, 4 + k % 24))
        $display("FAIL b2b_win k=%0d got %h required %h", k, obs_q[k], exp_win(4 + k / 24, 4 + k % 24));
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    fill_ramp();
    clear_obs();
    stream_frame(100, -1, 300, ok);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_total++;
    if (pack_out() !== '0 || o_valid !== 1'b0 || frame_done !== 1'b0 || s_axis_ready !== 1'b0)
      $display("FAIL midrst_outputs win=%h v=%b fd=%b rdy=%b required all 0", pack_out(), o_valid,
               frame_done, s_axis_ready);
    else n_pass++;
    @(posedge i_clk);
    #1;
    n_total++;
    if (s_axis_ready !== 1'b1) $display("FAIL midrst_ready got %b required 1", s_axis_ready);
    else n_pass++;
    clear_obs();
    stream_frame(100, -1, NPIX, ok);
    repeat (2) @(posedge i_clk);
    #1;
    n_total++;
    if (!ok || obs_q.size() != NWIN)
      $display("FAIL midrst_count ok=%b got %0d required %0d", ok, obs_q.size(), NWIN);
    else n_pass++;
    if (obs_q.size() > 0) begin
      n_total++;
      if (obs_pix[0] != 116 || obs_q[0][199:192] !== 8'd116 || obs_q[0][7:0] !== 8'd0)
        $display("FAIL midrst_first pix=%0d d24=%0d d0=%0d required 116 116 0", obs_pix[0],
                 obs_q[0][199:192], obs_q[0][7:0]);
      else n_pass++;
    end
    for (int k = 0; k < obs_q.size() && k < NWIN; k++) begin
      n_total++;
      if (obs_q[k] !== exp_win(4 + k / 24, 4 + k % 24))
        $display("FAIL midrst_win k=%0d got %h required %h", k, obs_q[k], exp_win(4 + k / 24, 4 + k % 24));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_weight_handshake();
    test_full_frame();
    test_random_valid();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
